// File: rtl/fir_kpow2_pkg.sv
// Shared types and sizing helpers for the power-of-two low-pass cascade.
package fir_kpow2_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fir_state_t;

    // Accumulator width: integer part plus retained fractional bits.
    function automatic int acc_width(input int data_width, input int frac_bits);
        return data_width + frac_bits;
    endfunction

    // Section index width; a single-section cascade still needs one bit.
    function automatic int idx_width(input int stages);
        return (stages > 1) ? $clog2(stages) : 1;
    endfunction

endpackage

// File: rtl/fir_kpow2_step_alu.sv
// One first-order section update: acc_new = acc + ((x - acc) >>> K).
// Purely combinational so one copy can be time-shared across sections.
module fir_kpow2_step_alu #(
    parameter int AW = 40,
    parameter int K  = 4
) (
    input  logic [AW-1:0] x,
    input  logic [AW-1:0] acc,
    output logic [AW-1:0] acc_new
);

    logic signed [AW:0] diff;
    logic signed [AW:0] step;
    logic signed [AW:0] sum;

    // Signed difference with one guard bit; the arithmetic shift floors toward
    // minus infinity, which keeps the result between x and acc, so truncating
    // the sum back to AW bits never wraps.
    always_comb begin
        diff    = $signed({1'b0, x}) - $signed({1'b0, acc});
        step    = diff >>> K;
        sum     = $signed({1'b0, acc}) + step;
        acc_new = AW'(sum);
    end

endmodule

// File: rtl/fir_filter_cascade_kpow2.sv
// Cascade of STAGES power-of-two low-pass sections sharing one step ALU.
// A captured sample walks the sections one per clock; the last section's
// integer part is presented on OUT_VALUE with a one-cycle OUT_VALID pulse.
//
//   state | meaning
//   IDLE  | waiting for IN_VALID; BUSY=0
//   RUN   | updating section idx_q this cycle; BUSY=1
module fir_filter_cascade_kpow2
    import fir_kpow2_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 8,
    parameter int K          = 4,
    parameter int STAGES     = 4,
    parameter int PRELOAD    = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  CLEAR,
    input  logic                  IN_VALID,
    input  logic [DATA_WIDTH-1:0] IN_VALUE,
    output logic                  BUSY,
    output logic                  OUT_VALID,
    output logic [DATA_WIDTH-1:0] OUT_VALUE,
    output logic                  OVERRUN
);

    localparam int AW = acc_width(DATA_WIDTH, FRAC_BITS);
    localparam int IW = idx_width(STAGES);
    localparam logic [IW-1:0] IDX_LAST = IW'(STAGES - 1);

    fir_state_t            state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [AW-1:0]         x_q, x_d;
    logic [AW-1:0]         acc_q [STAGES];
    logic [AW-1:0]         acc_d [STAGES];
    logic                  first_q, first_d;
    logic [DATA_WIDTH-1:0] out_value_q, out_value_d;
    logic                  out_valid_q, out_valid_d;
    logic                  overrun_q, overrun_d;

    logic [AW-1:0]         acc_sel;
    logic [AW-1:0]         alu_out;
    logic [AW-1:0]         upd;
    logic                  is_last;
    logic                  preload_active;

    // Select the accumulator of the section being updated this cycle.
    always_comb begin
        acc_sel = acc_q[0];
        for (int i = 1; i < STAGES; i++) begin
            if (idx_q == IW'(i)) begin
                acc_sel = acc_q[i];
            end
        end
    end

    fir_kpow2_step_alu #(
        .AW (AW),
        .K  (K)
    ) u_step_alu (
        .x       (x_q),
        .acc     (acc_sel),
        .acc_new (alu_out)
    );

    // x_q carries the input of the current section: the captured sample for
    // section 0, then each freshly written accumulator for the next one.
    // Preload bypasses the ALU so every section simply takes the sample.
    always_comb begin
        is_last        = (idx_q == IDX_LAST);
        preload_active = (PRELOAD != 0) && first_q;
        upd            = preload_active ? x_q : alu_out;
    end

    // Next-state logic; CLEAR always wins and aborts a computation in flight.
    always_comb begin
        state_d = state_q;
        if (CLEAR) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (IN_VALID) state_d = RUN;
                RUN:     if (is_last)  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath next values: capture, per-section writeback, output and overrun.
    always_comb begin
        idx_d       = idx_q;
        x_d         = x_q;
        acc_d       = acc_q;
        first_d     = first_q;
        out_value_d = out_value_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q;

        if (CLEAR) begin
            for (int i = 0; i < STAGES; i++) begin
                acc_d[i] = '0;
            end
            idx_d     = '0;
            first_d   = 1'b1;
            overrun_d = 1'b0;
        end else if (state_q == IDLE) begin
            if (IN_VALID) begin
                x_d   = AW'(IN_VALUE) << FRAC_BITS;
                idx_d = '0;
            end
        end else begin
            if (IN_VALID) begin
                overrun_d = 1'b1;
            end
            for (int i = 0; i < STAGES; i++) begin
                if (idx_q == IW'(i)) begin
                    acc_d[i] = upd;
                end
            end
            x_d = upd;
            if (is_last) begin
                out_value_d = DATA_WIDTH'(upd >> FRAC_BITS);
                out_valid_d = 1'b1;
                idx_d       = '0;
                first_d     = 1'b0;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
    end

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            idx_q       <= '0;
            x_q         <= '0;
            for (int i = 0; i < STAGES; i++) begin
                acc_q[i] <= '0;
            end
            first_q     <= 1'b1;
            out_value_q <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            x_q         <= x_d;
            acc_q       <= acc_d;
            first_q     <= first_d;
            out_value_q <= out_value_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    // Output decode.
    always_comb begin
        BUSY      = (state_q == RUN);
        OUT_VALID = out_valid_q;
        OUT_VALUE = out_value_q;
        OVERRUN   = overrun_q;
    end

endmodule

// File: tb/tb_fir_filter_cascade_kpow2.sv
// Bench for the kpow2 cascade: two instances (default preload configuration and
// a small non-preload one), a floor-division reference model, and a scoreboard
// monitor that checks value and latency of every OUT_VALID pulse.
module tb_fir_filter_cascade_kpow2;

    localparam int SA = 4;
    localparam int KA = 4;
    localparam int SB = 2;
    localparam int KB = 2;
    localparam longint SCALE = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        clear_a = 1'b0, in_valid_a = 1'b0;
    logic [31:0] in_value_a = '0;
    logic        busy_a, out_valid_a, overrun_a;
    logic [31:0] out_value_a;

    logic        clear_b = 1'b0, in_valid_b = 1'b0;
    logic [31:0] in_value_b = '0;
    logic        busy_b, out_valid_b, overrun_b;
    logic [31:0] out_value_b;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fir_filter_cascade_kpow2 #(
        .DATA_WIDTH(32), .FRAC_BITS(8), .K(KA), .STAGES(SA), .PRELOAD(1)
    ) dut_a (
        .CLK(clk), .RESET(rst), .CLEAR(clear_a), .IN_VALID(in_valid_a),
        .IN_VALUE(in_value_a), .BUSY(busy_a), .OUT_VALID(out_valid_a),
        .OUT_VALUE(out_value_a), .OVERRUN(overrun_a)
    );

    fir_filter_cascade_kpow2 #(
        .DATA_WIDTH(32), .FRAC_BITS(8), .K(KB), .STAGES(SB), .PRELOAD(0)
    ) dut_b (
        .CLK(clk), .RESET(rst), .CLEAR(clear_b), .IN_VALID(in_valid_b),
        .IN_VALUE(in_value_b), .BUSY(busy_b), .OUT_VALID(out_valid_b),
        .OUT_VALUE(out_value_b), .OVERRUN(overrun_b)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] v;
        int          c;
    } exp_t;

    exp_t   q_a[$];
    exp_t   q_b[$];
    longint acc_a[SA];
    longint acc_b[SB];
    bit     first_a;
    bit     conv_mode = 1'b0;
    logic [31:0] conv_prev;

    // One section: acc + floor((x - acc) / 2^k), using plain integer division.
    function automatic longint sec(input longint x, input longint acc, input int k);
        longint d, p, q;
        d = x - acc;
        p = longint'(1) << k;
        if (d >= 0) q = d / p;
        else        q = -((-d + p - 1) / p);
        return acc + q;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic reset_model_a();
        for (int i = 0; i < SA; i++) acc_a[i] = 0;
        first_a = 1'b1;
    endtask

    task automatic reset_model_b();
        for (int i = 0; i < SB; i++) acc_b[i] = 0;
    endtask

    task automatic model_a(input logic [31:0] v, output logic [31:0] o);
        longint x;
        x = longint'(v) * SCALE;
        if (first_a) begin
            for (int i = 0; i < SA; i++) acc_a[i] = x;
            first_a = 1'b0;
        end else begin
            for (int i = 0; i < SA; i++) begin
                acc_a[i] = sec(x, acc_a[i], KA);
                x = acc_a[i];
            end
        end
        o = 32'(acc_a[SA-1] / SCALE);
    endtask

    task automatic model_b(input logic [31:0] v, output logic [31:0] o);
        longint x;
        x = longint'(v) * SCALE;
        for (int i = 0; i < SB; i++) begin
            acc_b[i] = sec(x, acc_b[i], KB);
            x = acc_b[i];
        end
        o = 32'(acc_b[SB-1] / SCALE);
    endtask

    // Strobe one sample; when cap is set the sample is expected to be taken.
    task automatic issue_a(input logic [31:0] v, input bit cap);
        logic [31:0] o;
        @(negedge clk);
        in_valid_a = 1'b1;
        in_value_a = v;
        @(posedge clk);
        #1;
        in_valid_a = 1'b0;
        if (cap) begin
            model_a(v, o);
            q_a.push_back('{v: o, c: cyc + SA});
        end
    endtask

    task automatic send_a(input logic [31:0] v, input int gap);
        issue_a(v, 1'b1);
        repeat (SA + gap) @(posedge clk);
    endtask

    task automatic send_b(input logic [31:0] v, input int gap);
        logic [31:0] o;
        @(negedge clk);
        in_valid_b = 1'b1;
        in_value_b = v;
        @(posedge clk);
        #1;
        in_valid_b = 1'b0;
        model_b(v, o);
        q_b.push_back('{v: o, c: cyc + SB});
        repeat (SB + gap) @(posedge clk);
    endtask

    task automatic pulse_clear_a();
        @(negedge clk);
        clear_a = 1'b1;
        @(posedge clk);
        #1;
        clear_a = 1'b0;
        reset_model_a();
    endtask

    // Scoreboard monitor, instance A.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid_a) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_valid actual=%0h expected=none", out_value_a);
            end else begin
                e = q_a.pop_front();
                chk("a_value", {32'd0, out_value_a}, {32'd0, e.v});
                chk("a_latency", 64'(cyc), 64'(e.c));
                if (conv_mode) begin
                    chk("a_monotonic", {63'd0, out_value_a >= conv_prev}, 64'd1);
                    chk("a_no_overshoot", {63'd0, out_value_a <= 32'h4500_0000}, 64'd1);
                    conv_prev = out_value_a;
                end
            end
        end
    end

    // Scoreboard monitor, instance B.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid_b) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_valid actual=%0h expected=none", out_value_b);
            end else begin
                e = q_b.pop_front();
                chk("b_value", {32'd0, out_value_b}, {32'd0, e.v});
                chk("b_latency", 64'(cyc), 64'(e.c));
            end
        end
    end

    initial begin
        logic [31:0] v;
        reset_model_a();
        reset_model_b();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy_a}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid_a}, 64'd0);
        chk("rst_out_value", {32'd0, out_value_a}, 64'd0);
        chk("rst_overrun", {63'd0, overrun_a}, 64'd0);
        chk("rst_out_value_b", {32'd0, out_value_b}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Step without preload on the two-section instance.
        send_b(32'h100, 0);
        #1;
        chk("b_step_out", {32'd0, out_value_b}, 64'h10);
        for (int i = 0; i < 20; i++) begin
            send_b($urandom() & 32'h00ff_ffff, int'($urandom_range(0, 3)));
        end

        // Preload then constant input: output must equal input throughout.
        for (int i = 0; i < 21; i++) send_a(32'h1200_0000, 0);
        #1;
        chk("a_preload_const", {32'd0, out_value_a}, 64'h1200_0000);
        chk("a_preload_overrun", {63'd0, overrun_a}, 64'd0);

        // Step to a higher level at the minimum sample interval.
        conv_prev = 32'h1200_0000;
        conv_mode = 1'b1;
        for (int i = 0; i < 400; i++) send_a(32'h4500_0000, 0);
        repeat (2) @(posedge clk);
        #1;
        conv_mode = 1'b0;
        chk("a_conv_reach", {63'd0, (out_value_a > 32'h4500_0000 - 32'd32) &&
                                    (out_value_a <= 32'h4500_0000)}, 64'd1);

        // Random samples with random spacing.
        for (int i = 0; i < 30; i++) send_a($urandom(), int'($urandom_range(0, 4)));

        // Overrun: second strobe two cycles after the first is dropped.
        issue_a($urandom(), 1'b1);
        @(posedge clk);
        issue_a($urandom(), 1'b0);
        chk("a_overrun_set", {63'd0, overrun_a}, 64'd1);
        repeat (SA) @(posedge clk);
        for (int i = 0; i < 3; i++) send_a($urandom(), 1);
        #1;
        chk("a_overrun_sticky", {63'd0, overrun_a}, 64'd1);
        pulse_clear_a();
        chk("a_overrun_cleared", {63'd0, overrun_a}, 64'd0);

        // CLEAR while section 1 is being computed aborts without a pulse.
        send_a(32'h0000_1234, 2);
        issue_a($urandom(), 1'b0);
        @(posedge clk);
        pulse_clear_a();
        chk("a_clear_abort_busy", {63'd0, busy_a}, 64'd0);
        repeat (8) @(posedge clk);
        chk("a_clear_hold_value", {32'd0, out_value_a}, 64'h1234);
        v = $urandom();
        send_a(v, 0);
        #1;
        chk("a_clear_preload", {32'd0, out_value_a}, {32'd0, v});
        send_a($urandom(), 0);

        // CLEAR and IN_VALID together: sample is ignored.
        @(negedge clk);
        clear_a    = 1'b1;
        in_valid_a = 1'b1;
        in_value_a = $urandom();
        @(posedge clk);
        #1;
        clear_a    = 1'b0;
        in_valid_a = 1'b0;
        reset_model_a();
        chk("a_simul_busy", {63'd0, busy_a}, 64'd0);
        chk("a_simul_overrun", {63'd0, overrun_a}, 64'd0);
        repeat (SA + 2) @(posedge clk);

        // RESET mid-computation, asserted between clock edges.
        send_a(32'h00ab_cdef, 0);
        issue_a($urandom(), 1'b0);
        issue_a($urandom(), 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("a_rst_out_value", {32'd0, out_value_a}, 64'd0);
        chk("a_rst_busy", {63'd0, busy_a}, 64'd0);
        chk("a_rst_overrun", {63'd0, overrun_a}, 64'd0);
        chk("a_rst_out_valid", {63'd0, out_valid_a}, 64'd0);
        reset_model_a();
        reset_model_b();
        @(negedge clk);
        rst = 1'b0;
        v = $urandom();
        send_a(v, 0);
        #1;
        chk("a_after_rst_preload", {32'd0, out_value_a}, {32'd0, v});

        repeat (10) @(posedge clk);
        chk("a_queue_drained", 64'(q_a.size()), 64'd0);
        chk("b_queue_drained", 64'(q_b.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_filter_cascade_kpow2.md
Name: fir_filter_cascade_kpow2

Overview:
Parametrised successor to the single kpow2 smoothing stage in the theremin_sensor IP. It is a cascade of STAGES first-order power-of-two low-pass sections: each section computes acc += (x - acc) >>> K. All sections share one time-multiplexed subtract/shift/add datapath. The block sits between the period/frequency measurement and the AXI register readout. It replaces the PHASE-strobed two-cycle scheme with a valid handshake, and adds optional preload on the first sample, a synchronous clear, and overrun detection.

Parameters:
DATA_WIDTH, 32, width of IN_VALUE/OUT_VALUE (unsigned).
FRAC_BITS, 8, extra fractional bits kept in each accumulator.
K, 4, shift per section; legal range 1..16.
STAGES, 4, number of cascaded sections; legal range 1..8.
PRELOAD, 1, if 1, the first accepted sample after reset/CLEAR loads every accumulator directly.

Ports:
CLK  in  1  single clock, all logic rising-edge.
RESET  in  1  asynchronous, active-high; clears all state.
CLEAR  in  1  synchronous clear: accumulators=0, FSM→IDLE, OVERRUN=0, first-sample flag re-armed.
IN_VALID  in  1  one-cycle strobe; IN_VALUE is sampled when IN_VALID=1 and BUSY=0.
IN_VALUE  in  DATA_WIDTH  unsigned input sample.
BUSY  out  1  high while the cascade is being computed.
OUT_VALID  out  1  one-cycle pulse; a new OUT_VALUE is present.
OUT_VALUE  out  DATA_WIDTH  filtered output, held between pulses.
OVERRUN  out  1  sticky; set when IN_VALID=1 arrives while BUSY=1.

Behaviour:
- Reset values: BUSY=0, OUT_VALID=0, OUT_VALUE=0, OVERRUN=0, all acc=0, FSM=IDLE, first-sample flag=1.
- Accumulators are unsigned, AW=DATA_WIDTH+FRAC_BITS bits. x0 = IN_VALUE<<FRAC_BITS; xi = updated acc[i-1].
- Section update: diff = x - acc, signed AW+1 bits; step = diff >>> K (arithmetic, floor); acc_new = acc + step truncated to AW bits.
  - The result is provably in [min(x,acc), max(x,acc)], so no saturation logic is needed.
- FSM:
  - IDLE: on IN_VALID, capture x0 and go to RUN with idx=0; BUSY=1 from that edge.
  - RUN: one section per cycle. The edge with idx=i writes acc[i]; idx increments.
  - The edge writing acc[STAGES-1] also does three things: loads OUT_VALUE = acc_new[STAGES-1] >> FRAC_BITS (truncate), pulses OUT_VALID, and returns to IDLE with BUSY=0.
- Timing:
  - If capture is at edge t0, OUT_VALID is high in the cycle after edge t0+STAGES.
  - The next sample can be accepted in that same cycle, giving a minimum sample interval of STAGES+1 cycles.
- Preload: if PRELOAD=1 and the first-sample flag is set, the captured sample writes x0 into every acc in the RUN cycles instead of the filter update.
  - The output equals the input exactly, and the flag clears at the last-stage edge.
- Overrun: IN_VALID while BUSY sets OVERRUN; the sample is dropped and the computation in progress is unaffected. Only RESET or CLEAR clears OVERRUN.
- CLEAR has priority over IN_VALID in the same cycle, and the sample is dropped. CLEAR mid-RUN aborts: OUT_VALID does not pulse and OUT_VALUE keeps its last value.
- RESET mid-RUN: all outputs return to their reset values immediately (asynchronous).

Decomposition:
- Package fir_kpow2_pkg:
  - FSM enum fir_state_t {IDLE, RUN};
  - localparam function acc_width(DATA_WIDTH, FRAC_BITS);
  - idx width = $clog2(STAGES) (min 1).
- Sub-module fir_kpow2_step_alu: combinational (x, acc, K) → acc_new. It is parametrised by AW, instantiated once in the top, and reusable by the single-stage block.

Test Plan:
- Step, no preload. Config: PRELOAD=0, STAGES=2, K=2, FRAC=8. Stimulus: IN_VALUE=0x100, one strobe. Expected: acc0=0x4000, acc1=0x1000, OUT_VALUE=0x10, OUT_VALID exactly 2 cycles after capture edge.
- Preload. Config: PRELOAD=1, defaults. Stimulus: first sample 0x12000000, then 0x12000000 repeated 20×. Expected: every OUT_VALUE=0x12000000, OVERRUN=0.
- Convergence. Config: PRELOAD=1. Stimulus: 0x12000000, then a step to 0x45000000, samples every STAGES+1 cycles. Expected: OUT_VALUE monotonically non-decreasing, never >0x45000000, reaches 0x45000000 minus truncation (<2^(K+1)) within 400 samples.
- Overrun. Stimulus: strobes 2 cycles apart with STAGES=4. Expected: the second sample is dropped, OVERRUN=1 and stays 1 through later valid samples until CLEAR.
- Clear/reset mid-RUN. Stimulus: CLEAR at idx=1. Expected: no OUT_VALID pulse, next sample behaves as the first (preload). Stimulus: RESET mid-RUN. Expected: OUT_VALUE=0 and BUSY=0 immediately without a clock.
- Simultaneous events. Stimulus: CLEAR and IN_VALID in the same cycle. Expected: sample ignored, BUSY stays 0, OVERRUN stays 0.
